// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and state type for the programmable clock divider.
// Optional negedge duty correction is selected by ODD_DUTY50_EN in the top.
package clkdiv_pkg;
  localparam int CD_DIV_W = 8;
  localparam int MIN_DIV = 2;
  typedef enum logic {CD_IDLE, CD_RUN} cd_state_e;
endpackage

// File: rtl/clkdiv_half_stretch.sv
// clkdiv_half_stretch: negedge stage holding clk_out high an extra half cycle for odd divisors.
// Only built when ODD_DUTY50_EN is defined.
`ifdef ODD_DUTY50_EN
module clkdiv_half_stretch (
  input  logic clk_in,
  input  logic reset_n,
  input  logic d_i,
  input  logic odd_i,
  output logic q_o
);
  logic s_q;
  always_ff @(negedge clk_in)
    s_q <= reset_n ? d_i : 1'b0;
  assign q_o = d_i | (odd_i & s_q);
endmodule
`endif

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable divide-by-N with glitch-free divisor handover.
// Define ODD_DUTY50_EN to get exact 50% duty for odd N via a negedge stretch stage.
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = CD_DIV_W,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_busy,
  output logic             div_err,
  output logic [DIV_W-1:0] div_active,
  output logic             clk_out,
  output logic             tick
);
  if (DEFAULT_DIV < MIN_DIV || DEFAULT_DIV > 2**DIV_W - 1) begin : g_bad_default
    $error("DEFAULT_DIV out of range");
  end
  cd_state_e state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q;
  logic busy_q, err_q, clk_q, clk_d, wrap, apply, take, bad_val;
  always_comb begin
    wrap    = state_q == CD_RUN && cnt_q == act_q - 1'b1;
    apply   = busy_q && (state_q == CD_IDLE || wrap);
    bad_val = div_val < DIV_W'(MIN_DIV);
    take    = div_load && !busy_q && !bad_val;
    act_d   = apply ? pend_q : act_q;
    state_d = state_q == CD_IDLE ? (en ? CD_RUN : CD_IDLE) : (wrap && !en ? CD_IDLE : CD_RUN);
    cnt_d   = (state_q == CD_RUN && !wrap) ? cnt_q + 1'b1 : '0;
    clk_d   = state_d == CD_RUN && cnt_d < (act_d >> 1);
  end
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state_q <= CD_IDLE;
      cnt_q   <= '0;
      act_q   <= DIV_W'(DEFAULT_DIV);
      pend_q  <= DIV_W'(DEFAULT_DIV);
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      clk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      clk_q   <= clk_d;
      err_q   <= div_load && (busy_q || bad_val);
      busy_q  <= take || (busy_q && !apply);
      if (take) pend_q <= div_val;
    end
  end
  assign div_busy   = busy_q;
  assign div_err    = err_q;
  assign div_active = act_q;
  assign tick       = state_q == CD_RUN && cnt_q == '0;
`ifdef ODD_DUTY50_EN
  clkdiv_half_stretch u_stretch (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .d_i    (clk_q),
    .odd_i  (state_q == CD_RUN && act_q[0]),
    .q_o    (clk_out)
  );
`else
  assign clk_out = clk_q;
`endif
endmodule
